// File: rtl/apb_bridge_arbiter.sv
// Round-robin sequencer sharing the bridge's AHB slave port between NUM_REQ requesters.
// Optional wait-state timeout abort is enabled by defining ARB_TIMEOUT_EN.
module apb_bridge_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         Haddr,
    output logic [DATA_W-1:0]         Hwdata,
    output logic                      Hwrite,
    output logic [1:0]                Htrans,
    output logic                      Hreadyin,
    input  logic                      Hreadyout,
    input  logic [DATA_W-1:0]         Hrdata
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("apb_bridge_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    last_reg, last_next;
    logic [IDX_W-1:0]    owner_reg, owner_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [NUM_REQ-1:0]  done_reg, done_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [ADDR_W-1:0]   haddr_reg, haddr_next;
    logic [DATA_W-1:0]   hwdata_reg, hwdata_next;
    logic [DATA_W-1:0]   wdata_lat_reg, wdata_lat_next;
    logic                hwrite_reg, hwrite_next;
    logic [1:0]          htrans_reg, htrans_next;
    logic                hreadyin_reg;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                timeout_hit;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Scan from farthest to nearest so the requester closest after last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_reg) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last_reg) + k) % NUM_REQ);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_comb begin
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        if ((state_reg == ST_ADDR || state_reg == ST_DATA) && !Hreadyout) begin
            if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
            else                                    cnt_next    = cnt_reg + 1'b1;
        end
        if (state_next != state_reg) cnt_next = '0;
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        owner_next     = owner_reg;
        grant_next     = grant_reg;
        done_next      = '0;
        err_next       = 1'b0;
        rdata_next     = rdata_reg;
        haddr_next     = haddr_reg;
        hwdata_next    = hwdata_reg;
        wdata_lat_next = wdata_lat_reg;
        hwrite_next    = hwrite_reg;
        htrans_next    = htrans_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next     = NUM_REQ'(1) << pick_idx;
                    owner_next     = pick_idx;
                    haddr_next     = addr_arr[pick_idx];
                    hwrite_next    = req_write[pick_idx];
                    wdata_lat_next = wdata_arr[pick_idx];
                    htrans_next    = TR_NONSEQ;
                    state_next     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (Hreadyout) begin
                    htrans_next = TR_IDLE;
                    hwdata_next = wdata_lat_reg;
                    state_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (Hreadyout) begin
                    if (!hwrite_reg) rdata_next = Hrdata;
                    done_next[owner_reg] = 1'b1;
                    grant_next = '0;
                    last_next  = owner_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort a stalled phase: the owner still gets its done, flagged by err.
        if (timeout_hit) begin
            htrans_next          = TR_IDLE;
            done_next            = '0;
            done_next[owner_reg] = 1'b1;
            err_next             = 1'b1;
            grant_next           = '0;
            last_next            = owner_reg;
            state_next           = ST_IDLE;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_reg     <= ST_IDLE;
            last_reg      <= IDX_W'(NUM_REQ - 1);
            owner_reg     <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            haddr_reg     <= '0;
            hwdata_reg    <= '0;
            wdata_lat_reg <= '0;
            hwrite_reg    <= 1'b0;
            htrans_reg    <= TR_IDLE;
            hreadyin_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            owner_reg     <= owner_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            haddr_reg     <= haddr_next;
            hwdata_reg    <= hwdata_next;
            wdata_lat_reg <= wdata_lat_next;
            hwrite_reg    <= hwrite_next;
            htrans_reg    <= htrans_next;
            hreadyin_reg  <= 1'b1;
        end
    end

    assign grant    = grant_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign rdata    = rdata_reg;
    assign Haddr    = haddr_reg;
    assign Hwdata   = hwdata_reg;
    assign Hwrite   = hwrite_reg;
    assign Htrans   = htrans_reg;
    assign Hreadyin = hreadyin_reg;
endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Scoreboard bench for apb_bridge_arbiter: round-robin order model, bridge model, decoupled monitor.
// Covers the timeout abort when built with ARB_TIMEOUT_EN.
module tb_apb_bridge_arbiter;
    localparam int NUM_REQ     = 3;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam logic [31:0] RD_KEY = 32'hC3A5_0F96;

    logic                      Hclk = 1'b0;
    logic                      Hreset = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        grant, done;
    logic                      err;
    logic [DATA_W-1:0]         rdata, Hwdata, Hrdata;
    logic [ADDR_W-1:0]         Haddr;
    logic                      Hwrite, Hreadyin, Hreadyout;
    logic [1:0]                Htrans;

    apb_bridge_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
        .err(err), .rdata(rdata), .Haddr(Haddr), .Hwdata(Hwdata), .Hwrite(Hwrite),
        .Htrans(Htrans), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        int          idx;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          last_m = NUM_REQ - 1;
    int          mode = 0;   // bridge: 0 ready, 1 random waits, 2 stuck low, 3 two DATA waits
    logic [31:0] prev_rd = '0;

    function automatic logic [31:0] bridge_rd(input logic [31:0] a);
        return a ^ RD_KEY;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference order: strict rotation starting after the last served requester.
    task automatic push_batch(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] m;
        m = mask;
        while (m != 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (last_m + k) % NUM_REQ;
                if (m[c]) begin
                    exp_t e;
                    e.idx   = c;
                    e.write = req_write[c];
                    e.addr  = req_addr[c*ADDR_W +: ADDR_W];
                    e.wdata = req_wdata[c*DATA_W +: DATA_W];
                    e.rdata = bridge_rd(e.addr);
                    e.err   = 1'b0;
                    exp_q.push_back(e);
                    m[c]   = 1'b0;
                    last_m = c;
                    break;
                end
            end
        end
    endtask

    task automatic rand_slot(input int i);
        req_write[i]                  = 1'($urandom_range(0, 1));
        req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
        req_wdata[i*DATA_W +: DATA_W] = $urandom;
    endtask

    task automatic step(input bit drop);
        @(posedge Hclk);
        #1;
        if (drop) req = req & ~done;
    endtask

    task automatic wait_idle(input int budget, input bit scramble);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b1);
            if (scramble) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        rand_slot(i);
                        if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                    end
                end
            end
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Bridge model: read data derived from the presented address.
    initial begin
        int dcnt;
        dcnt      = 0;
        Hreadyout = 1'b1;
        Hrdata    = '0;
        forever begin
            @(posedge Hclk);
            #1;
            Hrdata = bridge_rd(Haddr);
            case (mode)
                0: Hreadyout = 1'b1;
                1: Hreadyout = ($urandom_range(0, 3) != 0);
                2: Hreadyout = 1'b0;
                default: begin
                    if (Htrans == 2'b10) dcnt = 0;
                    if (grant != 0 && Htrans == 2'b00 && dcnt < 2) begin
                        Hreadyout = 1'b0;
                        dcnt++;
                    end else begin
                        Hreadyout = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops one expected transfer per done pulse.
    initial begin
        forever begin
            @(negedge Hclk);
            if (Hreset) begin
                prev_rd = '0;
                continue;
            end
            if (done != 0 || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=%b err=%b with empty scoreboard", done, err);
                end else begin
                    exp_t e;
                    logic [31:0] want_rd;
                    e = exp_q.pop_front();
                    want_rd = (e.write || e.err) ? prev_rd : e.rdata;
                    chk("done_onehot", 64'(done), 64'(1 << e.idx));
                    chk("err_flag", 64'(err), 64'(e.err));
                    chk("rdata", 64'(rdata), 64'(want_rd));
                    chk("hreadyin", 64'(Hreadyin), 64'd1);
                    prev_rd = want_rd;
                    $display("txn req%0d %s addr=%h wdata=%h rdata=%h err=%0d",
                             e.idx, e.write ? "WR" : "RD", e.addr, e.wdata, rdata, err);
                end
            end
            if (Htrans == 2'b10) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nonseq: grant=%b haddr=%h", grant, Haddr);
                end else begin
                    chk("grant_addr_phase", 64'(grant), 64'(1 << exp_q[0].idx));
                    chk("haddr", 64'(Haddr), 64'(exp_q[0].addr));
                    chk("hwrite", 64'(Hwrite), 64'(exp_q[0].write));
                end
            end
            if (grant != 0 && Htrans == 2'b00 && exp_q.size() > 0 && exp_q[0].write)
                chk("hwdata", 64'(Hwdata), 64'(exp_q[0].wdata));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;
        logic [31:0] a0;

        // Reset held with all requests asserted.
        req = 3'b111;
        for (int i = 0; i < NUM_REQ; i++) rand_slot(i);
        repeat (3) step(1'b0);
        chk("reset_ctrl", 64'({grant, done, err, Htrans, Hwrite, Hreadyin}), 64'd0);
        chk("reset_haddr", 64'(Haddr), 64'd0);
        chk("reset_hwdata", 64'(Hwdata), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        Hreset = 1'b0;
        push_batch(3'b111);
        step(1'b1);
        chk("first_grant", 64'(grant), 64'b001);
        wait_idle(100, 1'b0);

        // Zero-wait write from requester 1: latency check.
        mode = 0;
        step(1'b1);
        step(1'b1);
        req_write[1]              = 1'b1;
        req_addr[1*ADDR_W +: 32]  = 32'h8000_000A;
        req_wdata[1*DATA_W +: 32] = 32'hAAAA_BBBB;
        req = 3'b010;
        push_batch(3'b010);
        step(1'b1);
        chk("lat_c1_htrans", 64'(Htrans), 64'b10);
        chk("lat_c1_haddr", 64'(Haddr), 64'h8000_000A);
        step(1'b1);
        chk("lat_c2_hwdata", 64'(Hwdata), 64'hAAAA_BBBB);
        chk("lat_c2_htrans", 64'(Htrans), 64'b00);
        step(1'b1);
        chk("lat_c3_done", 64'(done), 64'b010);
        wait_idle(20, 1'b0);

        // Read from requester 0 with two DATA wait states.
        mode = 3;
        step(1'b1);
        a0 = 32'h1234_5678 ^ RD_KEY;
        req_write[0]              = 1'b0;
        req_addr[0*ADDR_W +: 32]  = a0;
        req = 3'b001;
        push_batch(3'b001);
        ok = 1'b1;
        repeat (4) begin
            step(1'b1);
            if (done !== 3'b000) ok = 1'b0;
        end
        chk("wait_no_early_done", 64'(ok), 64'd1);
        step(1'b1);
        chk("wait_c5_done", 64'(done), 64'b001);
        chk("wait_c5_rdata", 64'(rdata), 64'h1234_5678);
        wait_idle(20, 1'b0);

        // All three held for six transfers: strict rotation, one done per grant.
        mode = 0;
        step(1'b1);
        for (int i = 0; i < NUM_REQ; i++) rand_slot(i);
        req = 3'b111;
        push_batch(3'b111);
        push_batch(3'b111);
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            step(1'b0);
            if (done != 0) n++;
        end
        req = '0;
        chk("rotation_done_count", 64'(n), 64'd6);
        step(1'b1);
        chk("rotation_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during a DATA phase aborts without done; pending requests restart rotation.
        for (int i = 0; i < NUM_REQ; i++) rand_slot(i);
        req = 3'b101;
        push_batch(3'b101);
        step(1'b1);
        step(1'b1);
        Hreset = 1'b1;
        exp_q.delete();
        step(1'b0);
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_htrans", 64'(Htrans), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        Hreset = 1'b0;
        last_m = NUM_REQ - 1;
        push_batch(req);
        step(1'b1);
        chk("rst_regrant", 64'(grant), 64'b001);
        wait_idle(40, 1'b0);

        // Randomised batches with random wait states and post-grant input changes.
        mode = 1;
        repeat (25) begin
            logic [NUM_REQ-1:0] mask;
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) if (mask[i]) rand_slot(i);
            req = req | mask;
            push_batch(mask);
            wait_idle(400, 1'b1);
        end

        // Bridge stuck in wait state.
        mode = 2;
        step(1'b1);
        step(1'b1);
        req_write[0] = 1'b0;
        req_addr[0*ADDR_W +: 32] = $urandom;
        req = 3'b001;
        push_batch(3'b001);
`ifdef ARB_TIMEOUT_EN
        exp_q[exp_q.size() - 1].err = 1'b1;
        n = 0;
        do begin
            step(1'b1);
            n++;
        end while (done == 0 && n < 40);
        chk("timeout_cycle", 64'(n), 64'(TIMEOUT_CYC + 1));
        chk("timeout_err", 64'(err), 64'd1);
        step(1'b1);
        chk("timeout_idle", 64'(grant), 64'd0);
        mode = 0;
        wait_idle(20, 1'b0);
`else
        step(1'b1);
        ok = 1'b1;
        repeat (100) begin
            step(1'b0);
            if (grant !== 3'b001 || done !== 3'b000 || err !== 1'b0) ok = 1'b0;
        end
        chk("stuck_grant_held", 64'(ok), 64'd1);
        mode = 0;
        wait_idle(20, 1'b0);
`endif
        step(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
